// File: rtl/cv32e40s_pkg.sv
// Shared types and encodings for the dummy-instruction generator slice of cv32e40s.
// Holds the kind/state enums, RV32 field constants and the instruction response type.
package cv32e40s_pkg;

  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;

  // Kind index matches the INSTR_EN bit that enables it
  typedef enum logic [1:0] {
    DUMMY_ADD  = 2'b00,
    DUMMY_MUL  = 2'b01,
    DUMMY_AND  = 2'b10,
    DUMMY_BLTU = 2'b11
  } dummy_instr_e;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_MUL  = 3'b000;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;
  localparam logic [2:0] FUNCT3_BLTU = 3'b110;

  localparam logic [6:0] FUNCT7_ADD = 7'b0000000;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;
  localparam logic [6:0] FUNCT7_AND = 7'b0000000;

  typedef enum logic [0:0] {
    DUMMY_COUNT = 1'b0,
    DUMMY_BURST = 1'b1
  } dummy_state_e;

  typedef enum logic [1:0] {
    MPU_OK       = 2'h0,
    MPU_RE_FAULT = 2'h1,
    MPU_WR_FAULT = 2'h2
  } mpu_status_e;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [4:0]  rchk;
    logic        integrity_err;
    logic        integrity;
  } obi_inst_resp_t;

  typedef struct packed {
    obi_inst_resp_t bus_resp;
    mpu_status_e    mpu_status;
  } inst_resp_t;

  function automatic logic [31:0] r_type(input logic [6:0] funct7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] funct3);
    return {funct7, rs2, rs1, funct3, 5'd0, OPCODE_OP};
  endfunction

  // imm is given as bits [12:1]; bit 0 of a branch offset is always zero
  function automatic logic [31:0] b_type(input logic [12:1] imm, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] funct3);
    return {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPCODE_BRANCH};
  endfunction

endpackage

// File: rtl/cv32e40s_dummy_gen_if.sv
// Signal bundle between the IF stage/controller (master) and the dummy generator (slave).
// Also carries the generator's internal state for observation.
interface cv32e40s_dummy_gen_if #(
  parameter int MAX_INTERVAL = 64,
  parameter int MAX_BURST    = 4
);
  import cv32e40s_pkg::*;

  localparam int CW = $clog2(MAX_INTERVAL + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  // Handshake: dummy_insert_o is a combinational request that may rise and fall freely;
  // a dummy is consumed only in a cycle where dummy_insert_o and instr_issued_i are both 1.
  logic           instr_issued_i;
  logic           first_op_nondummy_i;
  logic           prefetch_valid_i;
  logic           ptr_in_if_i;
  logic           allow_dummy_i;
  logic           en_i;
  logic [3:0]     freq_i;
  logic [BW-1:0]  burst_cfg_i;
  logic [31:0]    lfsr_i;
  logic           cntrst_i;

  logic           dummy_insert_o;
  inst_resp_t     dummy_instr_o;
  logic           burst_active_o;

  logic [CW-1:0]  dbg_cnt_o;
  logic [BW-1:0]  dbg_burst_left_o;
  dummy_state_e   dbg_state_o;

  modport master (
    output instr_issued_i, first_op_nondummy_i, prefetch_valid_i, ptr_in_if_i,
    output allow_dummy_i, en_i, freq_i, burst_cfg_i, lfsr_i, cntrst_i,
    input  dummy_insert_o, dummy_instr_o, burst_active_o,
    input  dbg_cnt_o, dbg_burst_left_o, dbg_state_o
  );

  modport slave (
    input  instr_issued_i, first_op_nondummy_i, prefetch_valid_i, ptr_in_if_i,
    input  allow_dummy_i, en_i, freq_i, burst_cfg_i, lfsr_i, cntrst_i,
    output dummy_insert_o, dummy_instr_o, burst_active_o,
    output dbg_cnt_o, dbg_burst_left_o, dbg_state_o
  );

endinterface

// File: rtl/cv32e40s_dummy_encode.sv
// Combinational encoder turning LFSR-selected fields into a dummy instruction response.
// All dummies write x0, so they have no architectural effect.
module cv32e40s_dummy_encode
  import cv32e40s_pkg::*;
#(
  parameter logic [3:0] INSTR_EN = 4'b1111
) (
  input  logic [1:0] kind_i,
  input  logic [4:0] rs1_i,
  input  logic [4:0] rs2_i,
  input  logic       insert_i,
  output inst_resp_t instr_o
);

  dummy_instr_e kind;
  logic [31:0]  word;

  assign kind = INSTR_EN[kind_i] ? dummy_instr_e'(kind_i) : DUMMY_ADD;

  always_comb begin
    word = r_type(FUNCT7_ADD, rs2_i, rs1_i, FUNCT3_ADD);
    case (kind)
      DUMMY_MUL:  word = r_type(FUNCT7_MUL, rs2_i, rs1_i, FUNCT3_MUL);
      DUMMY_AND:  word = r_type(FUNCT7_AND, rs2_i, rs1_i, FUNCT3_AND);
      // Offset 0 while inserting; offset 2 otherwise keeps the idle encoding a HINT-style branch
      DUMMY_BLTU: word = b_type(insert_i ? 12'd0 : 12'd1, rs2_i, rs1_i, FUNCT3_BLTU);
      default:    word = r_type(FUNCT7_ADD, rs2_i, rs1_i, FUNCT3_ADD);
    endcase
  end

  always_comb begin
    instr_o                = '0;
    instr_o.bus_resp.rdata = word;
    instr_o.mpu_status     = MPU_OK;
  end

endmodule

// File: rtl/cv32e40s_dummy_gen.sv
// Dummy instruction generator: counts issued instructions and, once the count exceeds an
// LFSR-derived threshold, requests a burst of dummy instructions at clean IF boundaries.
module cv32e40s_dummy_gen
  import cv32e40s_pkg::*;
#(
  parameter int         MAX_INTERVAL = 64,
  parameter int         MAX_BURST    = 4,
  parameter logic [3:0] INSTR_EN     = 4'b1111
) (
  input logic                clk,
  input logic                rst_n,
  cv32e40s_dummy_gen_if.slave dg
);

  localparam int W  = $clog2(MAX_INTERVAL);
  localparam int CW = $clog2(MAX_INTERVAL + 1);
  localparam int BW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;

  localparam logic [CW-1:0] CNT_MAX  = CW'(MAX_INTERVAL);
  localparam logic [W-1:0]  LOW_ONES = W'((1 << (W - 4)) - 1);

  dummy_state_e  state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [BW-1:0] burst_left_q, burst_left_d, burst_load;
  logic [W-1:0]  thr_mask, threshold;
  logic          dummy_en, boundary, over_thr, insert, take;

  assign dummy_en = dg.allow_dummy_i && dg.en_i;
  assign boundary = dg.first_op_nondummy_i && dg.prefetch_valid_i && !dg.ptr_in_if_i;

  // freq_i scales the upper threshold bits; the low W-4 bits always come straight from the LFSR
  assign thr_mask  = (W'(dg.freq_i) << (W - 4)) | LOW_ONES;
  assign threshold = dg.lfsr_i[24 +: W] & thr_mask;
  assign over_thr  = cnt_q > CW'(threshold);

  assign insert     = dummy_en && boundary && ((state_q == DUMMY_BURST) || over_thr);
  assign take       = insert && dg.instr_issued_i;
  assign burst_load = BW'(dg.lfsr_i[31:30]) & dg.burst_cfg_i;
  assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    burst_left_d = burst_left_q;
    if (!dummy_en || dg.cntrst_i) begin
      state_d      = DUMMY_COUNT;
      cnt_d        = '0;
      burst_left_d = '0;
    end else begin
      case (state_q)
        DUMMY_COUNT: begin
          if (take) begin
            cnt_d        = '0;
            burst_left_d = burst_load;
            state_d      = (burst_load != '0) ? DUMMY_BURST : DUMMY_COUNT;
          end else if (dg.instr_issued_i) begin
            cnt_d = cnt_inc;
          end
        end
        DUMMY_BURST: begin
          if (take) begin
            burst_left_d = burst_left_q - BW'(1);
            if (burst_left_q <= BW'(1)) begin
              state_d      = DUMMY_COUNT;
              cnt_d        = '0;
              burst_left_d = '0;
            end
          end else if (dg.instr_issued_i) begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d      = DUMMY_COUNT;
          cnt_d        = '0;
          burst_left_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= DUMMY_COUNT;
      cnt_q        <= '0;
      burst_left_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      burst_left_q <= burst_left_d;
    end
  end

  cv32e40s_dummy_encode #(
    .INSTR_EN (INSTR_EN)
  ) u_encode (
    .kind_i   (dg.lfsr_i[1:0]),
    .rs1_i    (dg.lfsr_i[12:8]),
    .rs2_i    (dg.lfsr_i[20:16]),
    .insert_i (insert),
    .instr_o  (dg.dummy_instr_o)
  );

  assign dg.dummy_insert_o   = insert;
  assign dg.burst_active_o   = (state_q == DUMMY_BURST);
  assign dg.dbg_cnt_o        = cnt_q;
  assign dg.dbg_burst_left_o = burst_left_q;
  assign dg.dbg_state_o      = state_q;

endmodule

// File: tb/tb_cv32e40s_dummy_gen.sv
// Self-checking bench for cv32e40s_dummy_gen: encoder vector table, directed burst/counter
// sequences and a randomized run against an integer reference model.
module tb_cv32e40s_dummy_gen;
  import cv32e40s_pkg::*;

  localparam int MAX_INTERVAL = 64;
  localparam int MAX_BURST    = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;
  logic [63:0] exp_q[$];

  // Reference model state (plain integers)
  int m_cnt;
  int m_left;
  bit m_burst;

  cv32e40s_dummy_gen_if #(.MAX_INTERVAL(MAX_INTERVAL), .MAX_BURST(MAX_BURST)) bus ();
  cv32e40s_dummy_gen_if #(.MAX_INTERVAL(MAX_INTERVAL), .MAX_BURST(MAX_BURST)) bus_ke ();

  assign bus_ke.instr_issued_i      = bus.instr_issued_i;
  assign bus_ke.first_op_nondummy_i = bus.first_op_nondummy_i;
  assign bus_ke.prefetch_valid_i    = bus.prefetch_valid_i;
  assign bus_ke.ptr_in_if_i         = bus.ptr_in_if_i;
  assign bus_ke.allow_dummy_i       = bus.allow_dummy_i;
  assign bus_ke.en_i                = bus.en_i;
  assign bus_ke.freq_i              = bus.freq_i;
  assign bus_ke.burst_cfg_i         = bus.burst_cfg_i;
  assign bus_ke.lfsr_i              = bus.lfsr_i;
  assign bus_ke.cntrst_i            = bus.cntrst_i;

  cv32e40s_dummy_gen #(.MAX_INTERVAL(MAX_INTERVAL), .MAX_BURST(MAX_BURST), .INSTR_EN(4'b1111)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dg    (bus)
  );

  cv32e40s_dummy_gen #(.MAX_INTERVAL(MAX_INTERVAL), .MAX_BURST(MAX_BURST), .INSTR_EN(4'b0111)) dut_ke (
    .clk   (clk),
    .rst_n (rst_n),
    .dg    (bus_ke)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  // Driver tasks
  task automatic drive_idle();
    bus.instr_issued_i      = 1'b0;
    bus.first_op_nondummy_i = 1'b1;
    bus.prefetch_valid_i    = 1'b1;
    bus.ptr_in_if_i         = 1'b0;
    bus.allow_dummy_i       = 1'b1;
    bus.en_i                = 1'b1;
    bus.freq_i              = 4'h0;
    bus.burst_cfg_i         = 2'b00;
    bus.lfsr_i              = 32'h0;
    bus.cntrst_i            = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    m_cnt   = 0;
    m_left  = 0;
    m_burst = 1'b0;
  endtask

  // One clock, then land at the sampling point (falling edge)
  task automatic edge_step();
    @(posedge clk);
    #1;
    @(negedge clk);
  endtask

  task automatic rand_inputs();
    bus.instr_issued_i      = 1'($urandom_range(0, 1));
    bus.first_op_nondummy_i = ($urandom_range(0, 7) != 0);
    bus.prefetch_valid_i    = ($urandom_range(0, 7) != 0);
    bus.ptr_in_if_i         = ($urandom_range(0, 7) == 0);
    bus.allow_dummy_i       = ($urandom_range(0, 63) != 0);
    bus.en_i                = ($urandom_range(0, 63) != 0);
    bus.cntrst_i            = ($urandom_range(0, 127) == 0);
    bus.freq_i              = 4'($urandom_range(0, 15));
    bus.burst_cfg_i         = 2'($urandom_range(0, 3));
    bus.lfsr_i              = $urandom;
  endtask

  // Reference model: expected instruction word built from RV32 field positions
  function automatic logic [31:0] exp_word(input logic [31:0] l, input bit ins, input logic [3:0] ien);
    int kind = int'(l[1:0]);
    int rs1  = int'(l[12:8]);
    int rs2  = int'(l[20:16]);
    int w;
    if (!ien[kind]) kind = 0;
    w = (rs2 << 20) | (rs1 << 15);
    case (kind)
      0:       w = w | 'h33;
      1:       w = w | (1 << 25) | 'h33;
      2:       w = w | (7 << 12) | 'h33;
      default: w = w | (6 << 12) | 'h63 | (ins ? 0 : (1 << 8));
    endcase
    return w;
  endfunction

  function automatic bit model_insert();
    int thr = int'(bus.lfsr_i[29:24]) & ((int'(bus.freq_i) << 2) | 3);
    bit den = bus.allow_dummy_i && bus.en_i;
    bit bnd = bus.first_op_nondummy_i && bus.prefetch_valid_i && !bus.ptr_in_if_i;
    return den && bnd && (m_burst || (m_cnt > thr));
  endfunction

  task automatic model_step(input bit ins);
    bit den = bus.allow_dummy_i && bus.en_i;
    int load;
    if (!den || bus.cntrst_i) begin
      m_cnt = 0; m_left = 0; m_burst = 1'b0;
    end else if (ins && bus.instr_issued_i) begin
      if (!m_burst) begin
        load    = int'(bus.lfsr_i[31:30] & bus.burst_cfg_i);
        m_cnt   = 0;
        m_left  = load;
        m_burst = (load != 0);
      end else begin
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_burst = 1'b0;
          m_cnt   = 0;
        end
      end
    end else if (bus.instr_issued_i) begin
      m_cnt = (m_cnt < MAX_INTERVAL) ? m_cnt + 1 : MAX_INTERVAL;
    end
  endtask

  typedef struct packed {
    logic [31:0] lfsr;
    logic [31:0] exp_main;
    logic [31:0] exp_ke;
  } enc_vec_t;

  enc_vec_t tbl[7];

  initial begin
    int ins_run;
    bit e_ins;
    n_checks = 0;
    n_errors = 0;

    tbl[0] = '{32'h0000_0000, 32'h0000_0033, 32'h0000_0033};
    tbl[1] = '{32'h0005_0300, 32'h0051_8033, 32'h0051_8033};
    tbl[2] = '{32'h0005_0301, 32'h0251_8033, 32'h0251_8033};
    tbl[3] = '{32'h0005_0302, 32'h0051_F033, 32'h0051_F033};
    tbl[4] = '{32'h0005_0303, 32'h0051_E163, 32'h0051_8033};
    tbl[5] = '{32'h001F_1F03, 32'h01FF_E163, 32'h01FF_8033};
    tbl[6] = '{32'hFFE0_E0E2, 32'h0000_7033, 32'h0000_7033};

    // Reset state, sampled while reset is held with an active-looking input set
    rst_n = 1'b0;
    drive_idle();
    bus.instr_issued_i = 1'b1;
    bus.lfsr_i         = 32'h8000_0000;
    @(negedge clk);
    check("rst_insert", 64'(bus.dummy_insert_o), 64'd0);
    check("rst_burst",  64'(bus.burst_active_o), 64'd0);
    check("rst_cnt",    64'(bus.dbg_cnt_o), 64'd0);
    check("rst_left",   64'(bus.dbg_burst_left_o), 64'd0);

    // Encoder table, insertion disabled
    do_reset();
    bus.en_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.lfsr_i = tbl[i].lfsr;
      @(negedge clk);
      check("tbl_insert", 64'(bus.dummy_insert_o), 64'd0);
      check("tbl_main",   64'(bus.dummy_instr_o.bus_resp.rdata), 64'(tbl[i].exp_main));
      check("tbl_ke",     64'(bus_ke.dummy_instr_o.bus_resp.rdata), 64'(tbl[i].exp_ke));
    end
    check("tbl_side", 64'({bus.dummy_instr_o.bus_resp.err, bus.dummy_instr_o.bus_resp.rchk,
                           bus.dummy_instr_o.bus_resp.integrity_err, bus.dummy_instr_o.bus_resp.integrity,
                           bus.dummy_instr_o.mpu_status}), 64'd0);

    // Threshold 3: insert appears once the count reaches 4
    do_reset();
    bus.lfsr_i         = 32'h3F00_0000;
    bus.instr_issued_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      edge_step();
      check("thr_cnt",    64'(bus.dbg_cnt_o), 64'(i));
      check("thr_insert", 64'(bus.dummy_insert_o), 64'(i == 4));
    end
    edge_step();
    check("thr_clear_cnt", 64'(bus.dbg_cnt_o), 64'd0);
    check("thr_no_burst",  64'(bus.burst_active_o), 64'd0);

    // Burst of 3 consecutive dummies
    do_reset();
    bus.lfsr_i         = 32'h8000_0000;
    bus.burst_cfg_i    = 2'b11;
    bus.instr_issued_i = 1'b1;
    ins_run = 0;
    edge_step();
    if (bus.dummy_insert_o) ins_run++;
    check("bst_first", 64'(bus.dummy_insert_o), 64'd1);
    edge_step();
    if (bus.dummy_insert_o) ins_run++;
    check("bst_active", 64'(bus.burst_active_o), 64'd1);
    check("bst_left2",  64'(bus.dbg_burst_left_o), 64'd2);
    edge_step();
    if (bus.dummy_insert_o) ins_run++;
    check("bst_left1",  64'(bus.dbg_burst_left_o), 64'd1);
    edge_step();
    check("bst_run",    64'(ins_run), 64'd3);
    check("bst_done",   64'(bus.burst_active_o), 64'd0);
    check("bst_cnt0",   64'(bus.dbg_cnt_o), 64'd0);
    check("bst_noins",  64'(bus.dummy_insert_o), 64'd0);

    // Burst stalls while prefetch is invalid; non-dummy issues still count
    do_reset();
    bus.lfsr_i         = 32'h8000_0000;
    bus.burst_cfg_i    = 2'b11;
    bus.instr_issued_i = 1'b1;
    edge_step();
    edge_step();
    bus.prefetch_valid_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      edge_step();
      check("stall_noins", 64'(bus.dummy_insert_o), 64'd0);
      check("stall_left",  64'(bus.dbg_burst_left_o), 64'd2);
    end
    check("stall_burst", 64'(bus.burst_active_o), 64'd1);
    check("stall_cnt",   64'(bus.dbg_cnt_o), 64'd5);

    // Counter reset wins over an insert+issue in the same cycle
    bus.prefetch_valid_i = 1'b1;
    bus.cntrst_i         = 1'b1;
    #1;
    check("crst_ins_req", 64'(bus.dummy_insert_o), 64'd1);
    edge_step();
    check("crst_cnt",   64'(bus.dbg_cnt_o), 64'd0);
    check("crst_state", 64'(bus.burst_active_o), 64'd0);
    check("crst_left",  64'(bus.dbg_burst_left_o), 64'd0);
    bus.cntrst_i = 1'b0;

    // Reset in the middle of a burst abandons it
    do_reset();
    bus.lfsr_i         = 32'h8000_0000;
    bus.burst_cfg_i    = 2'b11;
    bus.instr_issued_i = 1'b1;
    edge_step();
    edge_step();
    rst_n = 1'b0;
    #1;
    check("mrst_burst", 64'(bus.burst_active_o), 64'd0);
    check("mrst_left",  64'(bus.dbg_burst_left_o), 64'd0);
    check("mrst_ins",   64'(bus.dummy_insert_o), 64'd0);

    // BLTU offset depends on insertion; kind falls back to ADD when BLTU disabled
    do_reset();
    bus.lfsr_i         = 32'h0000_0003;
    bus.instr_issued_i = 1'b1;
    edge_step();
    bus.instr_issued_i = 1'b0;
    check("bltu_ins",    64'(bus.dummy_insert_o), 64'd1);
    check("bltu_imm0",   64'(bus.dummy_instr_o.bus_resp.rdata), 64'h0000_6063);
    check("bltu_ke_add", 64'(bus_ke.dummy_instr_o.bus_resp.rdata), 64'h0000_0033);
    bus.prefetch_valid_i = 1'b0;
    #1;
    check("bltu_noins", 64'(bus.dummy_insert_o), 64'd0);
    check("bltu_imm2",  64'(bus.dummy_instr_o.bus_resp.rdata), 64'h0000_6163);

    // Counter saturation without any boundary
    do_reset();
    bus.freq_i           = 4'hF;
    bus.lfsr_i           = 32'h3F00_0000;
    bus.prefetch_valid_i = 1'b0;
    bus.instr_issued_i   = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      edge_step();
      if (i == 64) check("sat_cnt64", 64'(bus.dbg_cnt_o), 64'd64);
    end
    check("sat_cnt100", 64'(bus.dbg_cnt_o), 64'd64);
    check("sat_noins",  64'(bus.dummy_insert_o), 64'd0);

    // Randomized run against the reference model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rand_inputs();
      @(negedge clk);
      e_ins = model_insert();
      exp_q.push_back({53'd0, e_ins, m_burst, 7'(m_cnt), 2'(m_left)});
      exp_q.push_back(64'(exp_word(bus.lfsr_i, e_ins, 4'b1111)));
      exp_q.push_back(64'(exp_word(bus.lfsr_i, e_ins, 4'b0111)));
      check("rnd_ctl", {53'd0, bus.dummy_insert_o, bus.burst_active_o, bus.dbg_cnt_o, bus.dbg_burst_left_o},
            exp_q.pop_front());
      check("rnd_instr",    64'(bus.dummy_instr_o.bus_resp.rdata), exp_q.pop_front());
      check("rnd_instr_ke", 64'(bus_ke.dummy_instr_o.bus_resp.rdata), exp_q.pop_front());
      @(posedge clk);
      model_step(e_ins);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
